// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state enum, J opcode and prefetch queue entry type for fetch_unit
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, HALTED} fetch_state_t;
  localparam logic [5:0] OPC_J = 6'b000010;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: flushable FIFO of fetch entries with a registered head (clk, rst, flush, push, pop, push_data -> head, full, empty)
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t push_data,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(QDEPTH);
  fetch_entry_t r_mem [QDEPTH];
  fetch_entry_t r_head;
  logic [AW:0] r_wr, r_rd;
  logic [AW:0] w_wr_nx, w_rd_nx;
  logic w_push, w_pop;
  assign empty = r_wr == r_rd;
  assign full = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_pop = pop && !empty && !flush;
  assign w_push = push && !flush && (!full || w_pop);
  assign w_wr_nx = r_wr + (AW+1)'(w_push);
  assign w_rd_nx = r_rd + (AW+1)'(w_pop);
  assign head = r_head;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr[AW-1:0]] <= push_data;
  // The head register tracks whatever entry will be at the front after this
  // edge; it holds its value whenever the queue becomes (or stays) empty.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
      r_head <= '0;
    end else if (flush) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      r_wr <= w_wr_nx;
      r_rd <= w_rd_nx;
      if (w_wr_nx != w_rd_nx)
        r_head <= (w_push && w_rd_nx == r_wr) ? push_data : r_mem[w_rd_nx[AW-1:0]];
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC/FSM owner issuing one imem fetch per cycle into a prefetch queue with redirect flush and halt.
// Ports: clk, rst (async, active-high); imem_addr/imem_en out, imem_rdata in;
// out_valid/out_instr/out_pc out, out_ready in; redirect_valid/redirect_pc in; halt_req in.
// Build option: FETCH_JUMP_PREDECODE_EN follows J instructions at fetch time.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        imem_en,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req
);
  fetch_state_t r_state, w_state_nx;
  logic [31:0] r_pc, w_pc_nx, w_pc_seq, w_pc_fetch;
  logic w_full, w_empty;
  fetch_entry_t w_head;
  assign out_valid = !w_empty;
  assign imem_addr = r_pc;
  assign imem_en = (r_state == FETCH) && (!w_full || (out_ready && out_valid)) && !redirect_valid;
  assign w_pc_seq = r_pc + 32'd4;
`ifdef FETCH_JUMP_PREDECODE_EN
  assign w_pc_fetch = (imem_rdata[31:26] == OPC_J) ? {w_pc_seq[31:28], imem_rdata[25:0], 2'b00} : w_pc_seq;
`else
  assign w_pc_fetch = w_pc_seq;
`endif
  assign w_pc_nx = redirect_valid ? {redirect_pc[31:2], 2'b00} : imem_en ? w_pc_fetch : r_pc;
  always_comb begin
    w_state_nx = r_state;
    if (redirect_valid) w_state_nx = FETCH;
    else if (r_state == IDLE) w_state_nx = FETCH;
    else if (r_state == FETCH && halt_req) w_state_nx = HALTED;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_pc <= RESET_PC;
    end else begin
      r_state <= w_state_nx;
      r_pc <= w_pc_nx;
    end
  fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (imem_en),
    .pop       (out_ready),
    .push_data ('{pc: r_pc, instr: imem_rdata}),
    .head      (w_head),
    .full      (w_full),
    .empty     (w_empty)
  );
  assign out_instr = w_head.instr;
  assign out_pc = w_head.pc;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit against a queue-based reference model
module tb_fetch_unit;
  localparam int QD = 2;
  localparam logic [31:0] RPC = 32'h0000_0000;
  logic clk, rst, imem_en, out_valid, out_ready, redirect_valid, halt_req;
  logic [31:0] imem_addr, imem_rdata, out_instr, out_pc, redirect_pc;
  int checks = 0, failures = 0, n;
  logic [31:0] q_pc[$], q_in[$];
  logic [31:0] m_pc, m_last_pc, m_last_in;
  int m_st;
  fetch_unit #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_en(imem_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_req(halt_req)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  function automatic logic [31:0] memf(logic [31:0] a);
    case (a)
      32'h0:  return 32'h8C01_0000;
      32'h4:  return 32'h8C02_0004;
      32'h8:  return 32'h0022_1820;
      32'h1C: return 32'h0800_0000;
      default: return {6'b001000, a[25:0]};
    endcase
  endfunction
  always @* imem_rdata = memf(imem_addr);
  function automatic logic [31:0] next_pc(logic [31:0] pc, logic [31:0] w);
    logic [31:0] p4;
    p4 = pc + 32'd4;
`ifdef FETCH_JUMP_PREDECODE_EN
    if (w[31:26] == 6'b000010) return {p4[31:28], w[25:0], 2'b00};
`endif
    return (w == 32'hFFFF_FFFF) ? pc : p4;
  endfunction
  function automatic bit m_en();
    return m_st == 1 && (q_pc.size() < QD || (out_ready && q_pc.size() > 0)) && !redirect_valid;
  endfunction
  task automatic model_reset();
    q_pc.delete();
    q_in.delete();
    m_pc = RPC;
    m_st = 0;
    m_last_pc = 0;
    m_last_in = 0;
  endtask
  task automatic model_update();
    logic [31:0] w;
    bit en;
    if (q_pc.size() > 0) begin
      m_last_pc = q_pc[0];
      m_last_in = q_in[0];
    end
    if (redirect_valid) begin
      q_pc.delete();
      q_in.delete();
      m_pc = redirect_pc & 32'hFFFF_FFFC;
      m_st = 1;
    end else begin
      en = m_en();
      w = memf(m_pc);
      if (out_ready && q_pc.size() > 0) begin
        void'(q_pc.pop_front());
        void'(q_in.pop_front());
      end
      if (en) begin
        q_pc.push_back(m_pc);
        q_in.push_back(w);
        m_pc = next_pc(m_pc, w);
      end
      if (m_st == 0) m_st = 1;
      else if (m_st == 1 && halt_req) m_st = 2;
    end
  endtask
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cmp_cycle();
    if (rst) return;
    chk("imem_en", 32'(imem_en), 32'(m_en()));
    chk("imem_addr", imem_addr, m_pc);
    chk("out_valid", 32'(out_valid), 32'(q_pc.size() > 0));
    chk("out_pc", out_pc, q_pc.size() > 0 ? q_pc[0] : m_last_pc);
    chk("out_instr", out_instr, q_in.size() > 0 ? q_in[0] : m_last_in);
  endtask
  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else model_update();
    @(negedge clk);
    cmp_cycle();
  endtask
  task automatic wait_addr(logic [31:0] a);
    for (int i = 0; i < 30 && imem_addr !== a; i++) step();
    chk("wait_addr", imem_addr, a);
  endtask
  initial begin
    rst = 1;
    out_ready = 1;
    redirect_valid = 0;
    redirect_pc = 0;
    halt_req = 0;
    model_reset();
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_en", 32'(imem_en), 0);
    chk("rst_addr", imem_addr, RPC);
    chk("rst_pc", out_pc, 0);
    chk("rst_instr", out_instr, 0);
    rst = 0;
    step();
    chk("start_en", 32'(imem_en), 1);
    chk("start_novalid", 32'(out_valid), 0);
    step();
    chk("start_pc0", out_pc, 32'h0);
    chk("start_i0", out_instr, 32'h8C01_0000);
    step();
    chk("start_pc4", out_pc, 32'h4);
    chk("start_i4", out_instr, 32'h8C02_0004);
    step();
    chk("start_pc8", out_pc, 32'h8);
    chk("start_i8", out_instr, 32'h0022_1820);
    // backpressure
    redirect_valid = 1;
    redirect_pc = 0;
    step();
    redirect_valid = 0;
    out_ready = 0;
    n = 0;
    repeat (5) begin
      #1 n += int'(imem_en);
      step();
    end
    chk("bp_fetches", 32'(n), 2);
    chk("bp_en", 32'(imem_en), 0);
    chk("bp_addr", imem_addr, 32'h8);
    chk("bp_head", out_pc, 32'h0);
    out_ready = 1;
    step();
    chk("bp_rel4", out_pc, 32'h4);
    step();
    chk("bp_rel8", out_pc, 32'h8);
    // redirect with a full queue and a simultaneous pop
    out_ready = 0;
    repeat (3) step();
    redirect_valid = 1;
    redirect_pc = 32'h19;
    out_ready = 1;
    #1 chk("rd_noen", 32'(imem_en), 0);
    chk("rd_valid", 32'(out_valid), 1);
    step();
    chk("rd_flushed", 32'(out_valid), 0);
    chk("rd_addr", imem_addr, 32'h18);
    redirect_valid = 0;
    step();
    chk("rd_newpc", out_pc, 32'h18);
    // halt and resume
    redirect_valid = 1;
    redirect_pc = 0;
    step();
    redirect_valid = 0;
    wait_addr(32'hC);
    halt_req = 1;
    step();
    halt_req = 0;
    chk("halt_en", 32'(imem_en), 0);
    chk("halt_addr", imem_addr, 32'h10);
    n = 0;
    repeat (4) begin
      #1 n += int'(imem_en);
      step();
    end
    chk("halt_fetches", 32'(n), 0);
    chk("halt_drained", 32'(out_valid), 0);
    chk("halt_held_pc", out_pc, 32'hC);
    redirect_valid = 1;
    redirect_pc = 0;
    halt_req = 1;
    step();
    redirect_valid = 0;
    halt_req = 0;
    step();
    chk("resume_pc", out_pc, 32'h0);
    // wrap, then asynchronous reset mid-stream
    redirect_valid = 1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 0;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap_next", imem_addr, 32'h0);
    chk("wrap_head", out_pc, 32'hFFFF_FFFC);
    step();
    #2 rst = 1;
    model_reset();
    #1 chk("arst_valid", 32'(out_valid), 0);
    chk("arst_en", 32'(imem_en), 0);
    chk("arst_addr", imem_addr, RPC);
    chk("arst_pc", out_pc, 0);
    step();
    rst = 0;
    step();
    step();
    chk("arst_restart", out_pc, RPC);
    chk("arst_instr", out_instr, 32'h8C01_0000);
    // J at 0x1C: followed only when predecode is built in
    redirect_valid = 1;
    redirect_pc = 32'h10;
    step();
    redirect_valid = 0;
    wait_addr(32'h1C);
    step();
`ifdef FETCH_JUMP_PREDECODE_EN
    chk("j_next", imem_addr, 32'h0);
`else
    chk("j_next", imem_addr, 32'h20);
`endif
    chk("j_head", out_pc, 32'h1C);
    step();
`ifdef FETCH_JUMP_PREDECODE_EN
    chk("j_after", out_pc, 32'h0);
`else
    chk("j_after", out_pc, 32'h20);
`endif
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
